lstm_weight_sequencer: RTL and testbench

Address sequencer and stream controller for the LSTM packed weight/bias ROM (two 8-bit halves forming one QZ-bit word).
- One `start` pulse walks one full timestep of parameters in row/gate order: Wih, then Whh, then bih, then bhh.
- Issues ROM addresses and absorbs the ROM read latency.
- Presents each word to the gate MAC array as a valid/ready stream tagged with kind, gate, row and column.
- Sits between the weight ROM and the LSTM MAC/accumulate datapath.

---
 rtl/lstm_seq_pkg.sv | 53 +++++
 rtl/lstm_weight_sequencer_if.sv | 17 +
 rtl/lstm_seq_fifo2.sv | 50 +++++
 rtl/lstm_weight_sequencer.sv | 171 +++++++++++++++++
 tb/tb_lstm_weight_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/lstm_seq_pkg.sv
// Shared types and memory-map helpers for the LSTM weight/bias sequencer.
// The ROM holds Wih, Whh, bih and bhh back to back, each gate-major.
package lstm_seq_pkg;

  // Tag row/col fields are carried at a fixed width; the top slices them to clog2(COL).
  localparam int IDX_W = 16;

  typedef enum logic [1:0] {
    KIND_WIH = 2'd0,
    KIND_WHH = 2'd1,
    KIND_BIH = 2'd2,
    KIND_BHH = 2'd3
  } kind_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WIH,
    S_WHH,
    S_BIH,
    S_BHH,
    S_DRAIN
  } state_e;

  typedef struct packed {
    kind_e            kind;
    logic [1:0]       gate;
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] col;
    logic             last;
  } beat_tag_t;

  function automatic int unsigned whh_base(input int unsigned col, input int unsigned cow);
    return col * cow * 4;
  endfunction

  function automatic int unsigned bih_base(input int unsigned col, input int unsigned cow);
    return whh_base(col, cow) + col * col * 4;
  endfunction

  function automatic int unsigned bhh_base(input int unsigned col, input int unsigned cow);
    return bih_base(col, cow) + col * 4;
  endfunction

  function automatic kind_e kind_of(input state_e s);
    case (s)
      S_WHH:   return KIND_WHH;
      S_BIH:   return KIND_BIH;
      S_BHH:   return KIND_BHH;
      default: return KIND_WIH;
    endcase
  endfunction

endpackage

// File: rtl/lstm_weight_sequencer_if.sv
// Tagged weight stream from the sequencer to the gate MAC array.
interface lstm_weight_sequencer_if #(
  parameter int QZ = 16,
  parameter int RW = 9
);
  logic [QZ-1:0] w_data;
  logic          w_valid;
  logic          w_ready;
  logic [1:0]    w_kind;
  logic [1:0]    w_gate;
  logic [RW-1:0] w_row;
  logic [RW-1:0] w_col;
  logic          w_last;

  modport master (output w_data, w_valid, w_kind, w_gate, w_row, w_col, w_last, input w_ready);
  modport slave  (input w_data, w_valid, w_kind, w_gate, w_row, w_col, w_last, output w_ready);
endinterface

// File: rtl/lstm_seq_fifo2.sv
// Two-entry FIFO holding ROM words with their beat tags; head drives the stream.
module lstm_seq_fifo2
  import lstm_seq_pkg::*;
#(
  parameter int QZ = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [QZ-1:0] push_data,
  input  beat_tag_t     push_tag,
  input  logic          pop,
  output logic [QZ-1:0] head_data,
  output beat_tag_t     head_tag,
  output logic [1:0]    count
);
  logic [QZ-1:0] data_mem [2];
  beat_tag_t     tag_mem  [2];
  logic          wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only two entries, so the storage is cleared too; that keeps the head tags at 0 out of reset.
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        tag_mem[i]  <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values regardless of statement order.
      if (do_push) begin
        data_mem[wr_ptr] <= push_data;
        tag_mem[wr_ptr]  <= push_tag;
        wr_ptr           <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_tag  = tag_mem[rd_ptr];

endmodule

// File: rtl/lstm_weight_sequencer.sv
// Walks one timestep of LSTM parameters (row, gate, Wih/Whh/bih/bhh), issues ROM
// reads, absorbs ROM latency and streams tagged words out through a 2-entry FIFO.
module lstm_weight_sequencer
  import lstm_seq_pkg::*;
#(
  parameter int COL     = 512,
  parameter int COW     = 96,
  parameter int QZ      = 16,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [QZ-1:0]     rom_data,
  lstm_weight_sequencer_if.master w
);
  localparam int RW = $clog2(COL);
  localparam logic [ADDR_W-1:0] WHH_BASE = ADDR_W'(whh_base(COL, COW));
  localparam logic [ADDR_W-1:0] BIH_BASE = ADDR_W'(bih_base(COL, COW));
  localparam logic [ADDR_W-1:0] BHH_BASE = ADDR_W'(bhh_base(COL, COW));

  state_e           state_q, state_d, beat_state;
  logic [1:0]       gate_q, gate_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic             issue, room, pop, push, inflight;
  logic [1:0]       occ;
  kind_e            cur_kind;
  beat_tag_t        cur_tag, push_tag, head_tag;
  logic [QZ-1:0]    head_data;
  logic [ADDR_W-1:0] g_a, r_a, c_a;

  // The start cycle itself issues beat 0 so the first word lands ROM_LAT+1 cycles later.
  assign beat_state = (state_q == S_IDLE) ? S_WIH : state_q;
  assign cur_kind   = kind_of(beat_state);
  assign pop        = w.w_valid && w.w_ready;
  // A word leaving this cycle frees its slot, which keeps one beat per cycle at ROM_LAT=1.
  assign room  = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue = room && (((state_q == S_IDLE) && start) ||
                          (state_q inside {S_WIH, S_WHH, S_BIH, S_BHH}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gate_q  <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case can infer a latch.
    state_d = state_q;
    gate_d  = gate_q;
    row_d   = row_q;
    col_d   = col_q;
    done    = 1'b0;
    if (issue) begin
      case (beat_state)
        S_WIH: begin
          state_d = S_WIH;
          if (col_q == IDX_W'(COW - 1)) begin
            col_d   = '0;
            state_d = S_WHH;
          end else col_d = col_q + 1'b1;
        end
        S_WHH: begin
          if (col_q == IDX_W'(COL - 1)) begin
            col_d   = '0;
            state_d = S_BIH;
          end else col_d = col_q + 1'b1;
        end
        S_BIH: state_d = S_BHH;
        S_BHH: begin
          state_d = S_WIH;
          if (gate_q == 2'd3) begin
            gate_d = 2'd0;
            if (row_q == IDX_W'(COL - 1)) begin
              row_d   = '0;
              state_d = S_DRAIN;
            end else row_d = row_q + 1'b1;
          end else gate_d = gate_q + 1'b1;
        end
        default: ;
      endcase
    end
    if ((state_q == S_DRAIN) && (occ == 2'd0) && !inflight) begin
      done    = 1'b1;
      state_d = S_IDLE;
    end
  end

  assign busy = (state_q != S_IDLE) && !done;

  assign g_a = ADDR_W'(gate_q);
  assign r_a = ADDR_W'(row_q);
  assign c_a = ADDR_W'(col_q);

  always_comb begin
    case (cur_kind)
      KIND_WIH: rom_addr = g_a * ADDR_W'(COL * COW) + r_a * ADDR_W'(COW) + c_a;
      KIND_WHH: rom_addr = WHH_BASE + g_a * ADDR_W'(COL * COL) + r_a * ADDR_W'(COL) + c_a;
      KIND_BIH: rom_addr = BIH_BASE + g_a * ADDR_W'(COL) + r_a;
      default:  rom_addr = BHH_BASE + g_a * ADDR_W'(COL) + r_a;
    endcase
  end

  always_comb begin
    cur_tag      = '0;
    cur_tag.kind = cur_kind;
    cur_tag.gate = gate_q;
    cur_tag.row  = row_q;
    cur_tag.col  = (cur_kind inside {KIND_WIH, KIND_WHH}) ? col_q : '0;
    cur_tag.last = (cur_kind == KIND_BHH);
  end

  generate
    if (ROM_LAT == 0) begin : g_lat0
      assign push     = issue;
      assign push_tag = cur_tag;
      assign inflight = 1'b0;
    end else begin : g_lat1
      logic      pend_q;
      beat_tag_t tag_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pend_q <= 1'b0;
          tag_q  <= '0;
        end else begin
          pend_q <= issue;
          if (issue) tag_q <= cur_tag;
        end
      end
      assign push     = pend_q;
      assign push_tag = tag_q;
      assign inflight = pend_q;
    end
  endgenerate

  lstm_seq_fifo2 #(.QZ(QZ)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rom_data),
    .push_tag  (push_tag),
    .pop       (pop),
    .head_data (head_data),
    .head_tag  (head_tag),
    .count     (occ)
  );

  logic unused_tag_bits;
  assign unused_tag_bits = ^{head_tag.row[IDX_W-1:RW], head_tag.col[IDX_W-1:RW]};

  assign w.w_valid = (occ != 2'd0);
  assign w.w_data  = head_data;
  assign w.w_kind  = head_tag.kind;
  assign w.w_gate  = head_tag.gate;
  assign w.w_row   = head_tag.row[RW-1:0];
  assign w.w_col   = head_tag.col[RW-1:0];
  assign w.w_last  = head_tag.last;

endmodule

// File: tb/tb_lstm_weight_sequencer.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors compare every
// presented beat (stalled or accepted) against the queue head.
module tb_lstm_weight_sequencer;

  localparam int COL = 8, COW = 3, QZ = 16, AW = 31, RW = 3;
  localparam int TOTAL = COL * 4 * (COW + COL + 2);  // 416
  // Hand-computed map for COL=8, COW=3: 8*3*4, +8*8*4, +8*4.
  localparam int WHH_B = 96, BIH_B = 352, BHH_B = 384;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  kind;
    logic [1:0]  gate;
    logic [2:0]  row;
    logic [2:0]  col;
    logic        last;
  } beat_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  // Registered-ROM instance
  logic start1, busy1, done1;
  logic [AW-1:0] addr1;
  logic [QZ-1:0] rom1;
  lstm_weight_sequencer_if #(.QZ(QZ), .RW(RW)) s1 ();
  lstm_weight_sequencer #(.COL(COL), .COW(COW), .QZ(QZ), .ROM_LAT(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rom_addr(addr1), .rom_data(rom1), .w(s1));
  always_ff @(posedge clk) rom1 <= addr1[QZ-1:0];

  // Combinational-ROM instance
  logic start0, busy0, done0;
  logic [AW-1:0] addr0;
  logic [QZ-1:0] rom0;
  lstm_weight_sequencer_if #(.QZ(QZ), .RW(RW)) s0 ();
  lstm_weight_sequencer #(.COL(COL), .COW(COW), .QZ(QZ), .ROM_LAT(0), .ADDR_W(AW)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .rom_addr(addr0), .rom_data(rom0), .w(s0));
  assign rom0 = addr0[QZ-1:0];

  beat_t golden [TOTAL];
  beat_t exp1 [$], exp0 [$];
  beat_t act1, act0;
  logic [15:0] obs_data1 [TOTAL];
  logic        obs_last1 [TOTAL];
  int n_pop1, n_done1, start_cyc1, lat1, pop_cyc1, done_cyc1;
  int n_pop0, n_done0, start_cyc0, lat0;
  bit seen1, seen0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n && s1.w_valid) begin
      act1 = '{s1.w_data, s1.w_kind, s1.w_gate, s1.w_row, s1.w_col, s1.w_last};
      if (!seen1) begin seen1 = 1'b1; lat1 = cyc - start_cyc1; end
      if (exp1.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL beat1: unexpected beat %0h", act1);
      end else begin
        check("beat1", 64'(act1), 64'(exp1[0]));
        if (s1.w_ready) begin
          if (n_pop1 < TOTAL) begin
            obs_data1[n_pop1] = s1.w_data;
            obs_last1[n_pop1] = s1.w_last;
          end
          n_pop1++;
          pop_cyc1 = cyc;
          void'(exp1.pop_front());
        end
      end
    end
    if (rst_n && done1) begin n_done1++; done_cyc1 = cyc; end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && s0.w_valid) begin
      act0 = '{s0.w_data, s0.w_kind, s0.w_gate, s0.w_row, s0.w_col, s0.w_last};
      if (!seen0) begin seen0 = 1'b1; lat0 = cyc - start_cyc0; end
      if (exp0.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL beat0: unexpected beat %0h", act0);
      end else begin
        check("beat0", 64'(act0), 64'(exp0[0]));
        if (s0.w_ready) begin n_pop0++; void'(exp0.pop_front()); end
      end
    end
    if (rst_n && done0) n_done0++;
  end

  // mode 0: ready=1, 1: random ready, 2: stall final beat 10 cycles, 3: extra start pulses
  task automatic sweep1(input int mode);
    int budget, hold;
    bit sp5, sp200;
    budget = 6000; hold = 0; sp5 = 1'b0; sp200 = 1'b0;
    foreach (golden[i]) exp1.push_back(golden[i]);
    n_pop1 = 0; n_done1 = 0; seen1 = 1'b0; start_cyc1 = cyc;
    s1.w_ready = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    while (n_done1 == 0 && budget > 0) begin
      s1.w_ready = 1'b1;
      if (mode == 1) s1.w_ready = 1'($urandom_range(0, 1));
      if (mode == 2 && n_pop1 == TOTAL - 1 && hold < 10) begin
        s1.w_ready = 1'b0;
        hold++;
        check("drain_busy", busy1, 1);
        check("drain_no_done", done1, 0);
      end
      start1 = 1'b0;
      if (mode == 3 && n_pop1 == 5 && !sp5) begin start1 = 1'b1; sp5 = 1'b1; end
      if (mode == 3 && n_pop1 == 200 && !sp200) begin start1 = 1'b1; sp200 = 1'b1; end
      @(posedge clk); #1;
      budget--;
    end
    start1 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("done_count", n_done1, 1);
    check("beat_count", n_pop1, TOTAL);
    check("done_after_last", done_cyc1 - pop_cyc1, 1);
    check("first_valid_lat1", lat1, 2);
    check("busy_after", busy1, 0);
    check("queue_empty", exp1.size(), 0);
  endtask

  initial begin
    int n, budget;
    n = 0;
    for (int r = 0; r < COL; r++) begin
      for (int g = 0; g < 4; g++) begin
        for (int c = 0; c < COW; c++) begin
          golden[n] = '{16'(g*COL*COW + r*COW + c), 2'd0, 2'(g), 3'(r), 3'(c), 1'b0}; n++;
        end
        for (int c = 0; c < COL; c++) begin
          golden[n] = '{16'(WHH_B + g*COL*COL + r*COL + c), 2'd1, 2'(g), 3'(r), 3'(c), 1'b0}; n++;
        end
        golden[n] = '{16'(BIH_B + g*COL + r), 2'd2, 2'(g), 3'(r), 3'd0, 1'b0}; n++;
        golden[n] = '{16'(BHH_B + g*COL + r), 2'd3, 2'(g), 3'(r), 3'd0, 1'b1}; n++;
      end
    end

    start1 = 1'b0; start0 = 1'b0;
    s1.w_ready = 1'b0; s0.w_ready = 1'b1;
    #1;
    check("reset_busy", busy1, 0);
    check("reset_done", done1, 0);
    check("reset_valid", s1.w_valid, 0);
    check("reset_addr", addr1, 0);
    check("reset_tags", {s1.w_kind, s1.w_gate, s1.w_row, s1.w_col, s1.w_last}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    sweep1(0);
    check("row1_gate2_wih_c0", obs_data1[78], 51);
    check("row1_gate2_whh_c7", obs_data1[88], 239);
    check("row1_gate2_bih", obs_data1[89], 369);
    check("row1_gate2_bhh", obs_data1[90], 401);
    check("row1_gate2_bhh_last", obs_last1[90], 1);

    sweep1(1);
    sweep1(3);
    sweep1(2);

    // Reset mid-sweep with the FIFO full and the stream stalled
    foreach (golden[i]) exp1.push_back(golden[i]);
    n_pop1 = 0; seen1 = 1'b0; start_cyc1 = cyc;
    s1.w_ready = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    budget = 1000;
    while (n_pop1 < 100 && budget > 0) begin @(posedge clk); #1; budget--; end
    s1.w_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_pops", n_pop1, 100);
    check("pre_reset_valid", s1.w_valid, 1);
    check("pre_reset_busy", busy1, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", s1.w_valid, 0);
    check("mid_reset_busy", busy1, 0);
    check("mid_reset_addr", addr1, 0);
    exp1.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    sweep1(0);

    // Combinational ROM: first beat one cycle after start
    foreach (golden[i]) exp0.push_back(golden[i]);
    n_pop0 = 0; n_done0 = 0; seen0 = 1'b0; start_cyc0 = cyc;
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    budget = 2000;
    while (n_done0 == 0 && budget > 0) begin @(posedge clk); #1; budget--; end
    repeat (3) begin @(posedge clk); #1; end
    check("lat0_done_count", n_done0, 1);
    check("lat0_beat_count", n_pop0, TOTAL);
    check("first_valid_lat0", lat0, 1);
    check("lat0_busy_after", busy0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
